// File: rtl/spi_slave_if.sv
// rtl/spi_slave_if.sv - SPI slave front end for the RAM command port: 10-bit command in, 8-bit read data out.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse for frames cut short by SS_n.
module spi_slave_if #(
   parameter int CMD_W  = 10,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [CMD_W-1:0]  rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_FRAME_ERR_EN
   input  logic              tx_valid,
   output logic              frame_err
`else
   input  logic              tx_valid
`endif
);

   localparam int CW  = $clog2(CMD_W);
   localparam int TLW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0]  LAST_BIT = CW'(CMD_W - 1);
   localparam logic [TLW-1:0] TX_LAST  = TLW'(DATA_W - 1);

   typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

   state_t             state, state_nxt;
   logic               rd_flag;
   logic [CW-1:0]      bit_cnt;
   logic [CMD_W-2:0]   rx_sh;
   logic               frame_done;
   logic [DATA_W-1:0]  tx_sh;
   logic [TLW-1:0]     tx_left;
   logic               tx_loaded;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (SS_n) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = CHK_CMD;
            CHK_CMD: begin
               if (!MOSI)       state_nxt = WRITE;
               else if (rd_flag) state_nxt = READ_DATA;
               else             state_nxt = READ_ADD;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         MISO       <= 1'b0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         rd_flag    <= 1'b0;
         bit_cnt    <= '0;
         rx_sh      <= '0;
         frame_done <= 1'b0;
         tx_sh      <= '0;
         tx_left    <= '0;
         tx_loaded  <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (SS_n) begin
            // rd_flag deliberately survives an abort
            MISO       <= 1'b0;
            bit_cnt    <= '0;
            frame_done <= 1'b0;
            tx_sh      <= '0;
            tx_left    <= '0;
            tx_loaded  <= 1'b0;
         end else begin
            case (state)
               CHK_CMD: begin
                  rx_sh   <= {rx_sh[CMD_W-3:0], MOSI};
                  bit_cnt <= CW'(1);
               end
               WRITE, READ_ADD, READ_DATA: begin
                  if (!frame_done) begin
                     if (bit_cnt == LAST_BIT) begin
                        rx_data    <= {rx_sh, MOSI};
                        rx_valid   <= 1'b1;
                        frame_done <= 1'b1;
                        if (state == READ_ADD)  rd_flag <= 1'b1;
                        if (state == READ_DATA) rd_flag <= 1'b0;
                     end else begin
                        rx_sh   <= {rx_sh[CMD_W-3:0], MOSI};
                        bit_cnt <= bit_cnt + CW'(1);
                     end
                  end else if (state == READ_DATA) begin
                     // tx_data captured once per frame; MISO carries the MSB from the capture edge
                     if (!tx_loaded) begin
                        if (tx_valid) begin
                           MISO      <= tx_data[DATA_W-1];
                           tx_sh     <= {tx_data[DATA_W-2:0], 1'b0};
                           tx_left   <= TX_LAST;
                           tx_loaded <= 1'b1;
                        end
                     end else if (tx_left != '0) begin
                        MISO    <= tx_sh[DATA_W-1];
                        tx_sh   <= {tx_sh[DATA_W-2:0], 1'b0};
                        tx_left <= tx_left - TLW'(1);
                     end else begin
                        MISO <= 1'b0;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SPI_FRAME_ERR_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         frame_err <= 1'b0;
      end else begin
         frame_err <= 1'b0;
         if (SS_n && state != IDLE) begin
            if (state == READ_DATA)
               frame_err <= !frame_done || !(tx_loaded && tx_left == '0);
            else
               frame_err <= !frame_done;
         end
      end
   end
`endif

endmodule

// File: tb/tb_spi_slave_if.sv
// tb/tb_spi_slave_if.sv - directed self-checking bench for spi_slave_if.
// Checks frame_err only when SPI_FRAME_ERR_EN is defined.
module tb_spi_slave_if;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       SS_n = 1'b1;
   logic       MOSI = 1'b0;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
`ifdef SPI_FRAME_ERR_EN
   logic       frame_err;
`endif

   int checks = 0;
   int failures = 0;
   int vld_cnt = 0;
   int miso_hi = 0;
   int v0, m0;
   logic [7:0] exp_byte;

   always #5 clk = ~clk;

   spi_slave_if #(.CMD_W(10), .DATA_W(8)) dut (
      .clk(clk), .rstn(rstn), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
      .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
`ifdef SPI_FRAME_ERR_EN
      .tx_valid(tx_valid), .frame_err(frame_err)
`else
      .tx_valid(tx_valid)
`endif
   );

   always @(negedge clk) begin
      if (rx_valid === 1'b1) vld_cnt++;
      if (MISO === 1'b1) miso_hi++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [9:0] w, input int nbits);
      @(negedge clk);
      SS_n = 1'b0;
      @(posedge clk);
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         MOSI = w[9-i];
         @(posedge clk);
      end
   endtask

   task automatic end_frame();
      @(negedge clk);
      SS_n = 1'b1;
      MOSI = 1'b0;
      @(posedge clk);
   endtask

   initial begin
      // reset
      settle();
      chk("reset_miso", MISO, 0);
      chk("reset_rx_data", rx_data, 0);
      chk("reset_rx_valid", rx_valid, 0);
`ifdef SPI_FRAME_ERR_EN
      chk("reset_frame_err", frame_err, 0);
`endif
      rstn = 1'b1;
      settle();

      // 1 write address
      v0 = vld_cnt;
      send_frame(10'h005, 10);
      chk("wr_addr_no_early_valid", vld_cnt - v0, 0);
      settle();
      chk("wr_addr_valid", rx_valid, 1);
      chk("wr_addr_data", rx_data, 10'h005);
      settle();
      chk("wr_addr_valid_drop", rx_valid, 0);
      end_frame();

      // 2 write data with trailing extra bits
      v0 = vld_cnt;
      send_frame(10'h1A5, 10);
      settle();
      chk("wr_data_valid", rx_valid, 1);
      chk("wr_data_data", rx_data, 10'h1A5);
      for (int i = 0; i < 3; i++) begin
         MOSI = 1'b1;
         settle();
      end
      chk("wr_data_one_pulse", vld_cnt - v0, 1);
      chk("write_miso_quiet", miso_hi, 0);
      end_frame();

      // 5 abort after 5 bits, then a full frame
      v0 = vld_cnt;
      send_frame(10'h0AA, 5);
      end_frame();
      settle();
`ifdef SPI_FRAME_ERR_EN
      chk("abort_frame_err", frame_err, 1);
`endif
      settle();
`ifdef SPI_FRAME_ERR_EN
      chk("abort_frame_err_drop", frame_err, 0);
`endif
      chk("abort_no_valid", vld_cnt - v0, 0);
      send_frame(10'h0F0, 10);
      settle();
      chk("post_abort_valid", rx_valid, 1);
      chk("post_abort_data", rx_data, 10'h0F0);
      end_frame();

      // 3 read address then read data
      send_frame(10'h205, 10);
      settle();
      chk("rd_addr_data", rx_data, 10'h205);
      end_frame();
      tx_data = 8'hA5;
      exp_byte = 8'hA5;
      send_frame(10'h3C3, 10);
      settle();
      chk("rd_data_valid", rx_valid, 1);
      chk("rd_data_opcode", rx_data[9:8], 2'b11);
      chk("rd_data_wait_miso", MISO, 0);
      tx_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         settle();
         chk($sformatf("miso_bit%0d", 7 - i), MISO, exp_byte[7-i]);
      end
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("miso_after_byte", MISO, 0);
      end
      end_frame();
      settle();
`ifdef SPI_FRAME_ERR_EN
      chk("full_read_no_err", frame_err, 0);
`endif

      // 4 read-data opcode with rd_flag clear decodes as read address
      m0 = miso_hi;
      send_frame(10'h3C3, 10);
      settle();
      chk("rd_flag0_valid", rx_valid, 1);
      repeat (12) settle();
      chk("rd_flag0_no_miso", miso_hi - m0, 0);
      end_frame();

      // 6 reset during MISO shifting
      send_frame(10'h3C3, 10);
      settle();
      chk("rd6_valid", rx_valid, 1);
      settle();
      chk("rd6_bit7", MISO, 1);
      settle();
      chk("rd6_bit6", MISO, 0);
      settle();
      chk("rd6_bit5", MISO, 1);
      rstn = 1'b0;
      #1;
      chk("rst_mid_miso", MISO, 0);
      chk("rst_mid_rx_valid", rx_valid, 0);
      chk("rst_mid_rx_data", rx_data, 0);
      settle();
      SS_n = 1'b1;
      rstn = 1'b1;
      settle();
      m0 = miso_hi;
      send_frame(10'h3C3, 10);
      settle();
      chk("post_rst_valid", rx_valid, 1);
      repeat (12) settle();
      chk("post_rst_rd_flag_clear", miso_hi - m0, 0);
      end_frame();
      send_frame(10'h3C3, 10);
      settle();
      chk("post_rst_rd_valid", rx_valid, 1);
      settle();
      chk("post_rst_rd_bit7", MISO, 1);
      end_frame();
      settle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
